// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-atomic AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int MAX_SRC = 16;

  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of mask after 'last', wrapping modulo n; returns last if mask is empty.
  function automatic logic [3:0] rr_next(input logic [MAX_SRC-1:0] mask, input int last,
                                         input int n);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = last[3:0];
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = (last + k) % n;
      if (k <= n && !found && mask[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational rotate-priority encoder: first requester after last_grant.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [SRC_W-1:0]   pick,
  output logic               any_req
);

  logic [MAX_SRC-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_SRC-1:0] = req;
    pick                 = SRC_W'(rr_next(req_ext, int'(last_grant), NUM_SRC));
    any_req              = |req;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI-Stream sink between NUM_SRC sources.
// state | meaning
// IDLE  | no grant held; pick next requester (one cycle)
// GRANT | granted source owns the output until tlast or forced termination
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SRC   = 4,
  parameter  int BITWIDTH  = 32,
  parameter  int MAX_BEATS = 64,
  localparam int SRC_W     = src_width(NUM_SRC)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          s_axis_tvalid,
  output logic [NUM_SRC-1:0]          s_axis_tready,
  input  logic [NUM_SRC*BITWIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]          s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [BITWIDTH-1:0]         m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [SRC_W-1:0]            m_axis_tid,
  output logic                        busy,
  output logic [31:0]                 pkt_count,
  output logic                        err_overlength
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t              state;
  logic [SRC_W-1:0]    grant;
  logic [SRC_W-1:0]    last_grant;
  logic [SRC_W-1:0]    pick;
  logic                any_req;
  logic [CNT_W-1:0]    beat_cnt;
  logic                src_hs;
  logic                m_hs;
  logic                src_last;
  logic                overlen;
  logic [BITWIDTH-1:0] src_data;

  axis_rr_picker #(
    .NUM_SRC(NUM_SRC),
    .SRC_W  (SRC_W)
  ) u_picker (
    .req       (s_axis_tvalid),
    .last_grant(last_grant),
    .pick      (pick),
    .any_req   (any_req)
  );

  // Ready depends on the output register draining so a held beat is never overwritten.
  always_comb begin
    s_axis_tready = '0;
    if (state == GRANT) s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready;
  end

  assign src_data = s_axis_tdata[grant*BITWIDTH +: BITWIDTH];
  assign src_last = s_axis_tlast[grant];
  assign src_hs   = (state == GRANT) && s_axis_tvalid[grant] && s_axis_tready[grant];
  assign m_hs     = m_axis_tvalid && m_axis_tready;
  assign overlen  = (beat_cnt == CNT_W'(MAX_BEATS - 1)) && !src_last;
  assign busy     = (state == GRANT) || m_axis_tvalid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= '0;
      last_grant     <= SRC_W'(NUM_SRC - 1);
      beat_cnt       <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tlast   <= 1'b0;
      m_axis_tid     <= '0;
      pkt_count      <= '0;
      err_overlength <= 1'b0;
    end else begin
      if (m_hs && m_axis_tlast) pkt_count <= pkt_count + 32'd1;

      if (src_hs) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= src_data;
        m_axis_tlast  <= src_last || overlen;
        m_axis_tid    <= grant;
        beat_cnt      <= beat_cnt + CNT_W'(1);
      end else if (m_hs) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            beat_cnt   <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          // Runaway packet: the remaining beats come back as a new packet after re-arbitration.
          if (src_hs && (src_last || overlen)) begin
            state <= IDLE;
            if (overlen) err_overlength <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed scoreboard bench for axis_rr_arbiter (NUM_SRC=4, MAX_BEATS=8).
module tb_axis_rr_arbiter;

  localparam int NUM_SRC = 4;
  localparam int BW      = 32;
  localparam int MAXB    = 8;
  localparam int SRC_W   = 2;

  typedef struct packed {
    logic          last;
    logic [BW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [SRC_W-1:0] tid;
    logic [BW-1:0]    data;
    logic             last;
  } exp_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_SRC-1:0]    s_axis_tvalid = '0;
  logic [NUM_SRC-1:0]    s_axis_tready;
  logic [NUM_SRC*BW-1:0] s_axis_tdata = '0;
  logic [NUM_SRC-1:0]    s_axis_tlast = '0;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready = 1'b1;
  logic [BW-1:0]         m_axis_tdata;
  logic                  m_axis_tlast;
  logic [SRC_W-1:0]      m_axis_tid;
  logic                  busy;
  logic [31:0]           pkt_count;
  logic                  err_overlength;

  axis_rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .BITWIDTH (BW),
    .MAX_BEATS(MAXB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .err_overlength(err_overlength)
  );

  always #5 clock = ~clock;

  beat_t       src_q[NUM_SRC][$];
  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rdy_mode = 0;
  int          first_out = -1;
  int          last_out  = -1;
  logic [31:0] m_hist   = '0;
  logic [31:0] s_hist   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_beat(input int src, input logic [BW-1:0] data, input logic last);
    beat_t b;
    b.last = last;
    b.data = data;
    src_q[src].push_back(b);
  endtask

  task automatic push_exp(input int tid, input logic [BW-1:0] data, input logic last);
    exp_t e;
    e.tid  = SRC_W'(tid);
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int i = 0; i < NUM_SRC; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
  endtask

  // One clock: drive sources from their queues, settle, score the handshakes of this cycle.
  task automatic cycle();
    logic [NUM_SRC-1:0] shs;
    logic               mhs;
    exp_t               e;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis_tvalid[i]          = 1'b1;
        s_axis_tdata[i*BW +: BW]  = src_q[i][0].data;
        s_axis_tlast[i]           = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i]          = 1'b0;
        s_axis_tdata[i*BW +: BW]  = '0;
        s_axis_tlast[i]           = 1'b0;
      end
    end
    m_axis_tready = (rdy_mode == 0) ? 1'b1 : ~cyc[0];
    #1;
    shs = s_axis_tvalid & s_axis_tready;
    mhs = m_axis_tvalid & m_axis_tready;
    if (m_axis_tvalid && !m_axis_tready) check("stall_ready", 64'(s_axis_tready), 64'(0));
    for (int i = 0; i < NUM_SRC; i++) if (shs[i]) void'(src_q[i].pop_front());
    if (mhs) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'({m_axis_tid, m_axis_tdata, m_axis_tlast}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({m_axis_tid, m_axis_tdata, m_axis_tlast}), 64'(e));
      end
    end
    if (cyc < 32) begin
      m_hist[cyc[4:0]] = mhs;
      s_hist[cyc[4:0]] = |shs;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 64'(pending()), 64'(0));
    clear_queues();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_queues();
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    rdy_mode      = 0;
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b0;
    cyc       = 0;
    first_out = -1;
    last_out  = -1;
    m_hist    = '0;
    s_hist    = '0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_m_valid", 64'(m_axis_tvalid), 64'(0));
    check("rst_s_ready", 64'(s_axis_tready), 64'(0));
    check("rst_outputs", 64'({m_axis_tdata, m_axis_tlast, m_axis_tid}), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_err", 64'(err_overlength), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Single 4-beat packet from source 0, sink always ready
    for (int b = 0; b < 4; b++) begin
      push_beat(0, 32'hA000_0000 + 32'(b), b == 3);
      push_exp(0, 32'hA000_0000 + 32'(b), b == 3);
    end
    repeat (8) cycle();
    check("t1_src_hs_cycles", 64'(s_hist[7:0]), 64'(8'b0001_1110));
    check("t1_out_cycles", 64'(m_hist[7:0]), 64'(8'b0011_1100));
    check("t1_pkt_count", 64'(pkt_count), 64'(1));
    drain("t1", 4);

    // Four sources, two 2-beat packets each: strict rotation, one bubble per boundary
    do_reset();
    for (int s = 0; s < NUM_SRC; s++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 2; b++)
          push_beat(s, 32'hB000_0000 | 32'(s << 8) | 32'(p << 4) | 32'(b), b == 1);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NUM_SRC; s++)
        for (int b = 0; b < 2; b++)
          push_exp(s, 32'hB000_0000 | 32'(s << 8) | 32'(p << 4) | 32'(b), b == 1);
    drain("t2", 60);
    check("t2_out_span", 64'(last_out - first_out), 64'(22));
    check("t2_pkt_count", 64'(pkt_count), 64'(8));

    // 8-beat packet (exactly MAX_BEATS) under a 1,0,1,0 sink-ready pattern
    do_reset();
    rdy_mode = 1;
    for (int b = 0; b < 8; b++) begin
      push_beat(0, 32'hC000_0000 + 32'(b), b == 7);
      push_exp(0, 32'hC000_0000 + 32'(b), b == 7);
    end
    drain("t3", 60);
    check("t3_pkt_count", 64'(pkt_count), 64'(1));
    check("t3_no_err", 64'(err_overlength), 64'(0));
    rdy_mode = 0;

    // After grant to source 2, sources 1 and 3 waiting: 3 is served before 1
    do_reset();
    push_beat(2, 32'hD200_0000, 1'b0);
    push_beat(2, 32'hD200_0001, 1'b1);
    cycle();
    for (int b = 0; b < 2; b++) begin
      push_beat(1, 32'hD100_0000 + 32'(b), b == 1);
      push_beat(3, 32'hD300_0000 + 32'(b), b == 1);
    end
    push_exp(2, 32'hD200_0000, 1'b0);
    push_exp(2, 32'hD200_0001, 1'b1);
    for (int b = 0; b < 2; b++) push_exp(3, 32'hD300_0000 + 32'(b), b == 1);
    for (int b = 0; b < 2; b++) push_exp(1, 32'hD100_0000 + 32'(b), b == 1);
    drain("t5", 40);
    check("t5_pkt_count", 64'(pkt_count), 64'(3));

    // Runaway packet: 10 beats from source 2, tlast only on beat 10
    do_reset();
    check("t4_err_before", 64'(err_overlength), 64'(0));
    for (int b = 0; b < 10; b++) begin
      push_beat(2, 32'hE000_0000 + 32'(b), b == 9);
      push_exp(2, 32'hE000_0000 + 32'(b), (b == 7) || (b == 9));
    end
    drain("t4", 60);
    check("t4_err_set", 64'(err_overlength), 64'(1));
    check("t4_pkt_count", 64'(pkt_count), 64'(2));
    repeat (4) cycle();
    check("t4_err_sticky", 64'(err_overlength), 64'(1));

    // Reset asserted while beat 2 of a 4-beat packet is being transferred
    for (int b = 0; b < 4; b++) begin
      push_beat(0, 32'hF000_0000 + 32'(b), b == 3);
      push_exp(0, 32'hF000_0000 + 32'(b), b == 3);
    end
    repeat (2) cycle();
    check("t6_mid_valid", 64'(m_axis_tvalid), 64'(1));
    reset = 1'b1;
    #1;
    check("t6_rst_m_valid", 64'(m_axis_tvalid), 64'(0));
    check("t6_rst_s_ready", 64'(s_axis_tready), 64'(0));
    check("t6_rst_pkt_count", 64'(pkt_count), 64'(0));
    check("t6_rst_err", 64'(err_overlength), 64'(0));
    do_reset();
    for (int b = 0; b < 2; b++) begin
      push_beat(1, 32'h6100_0000 + 32'(b), b == 1);
      push_beat(0, 32'h6000_0000 + 32'(b), b == 1);
    end
    for (int b = 0; b < 2; b++) push_exp(0, 32'h6000_0000 + 32'(b), b == 1);
    for (int b = 0; b < 2; b++) push_exp(1, 32'h6100_0000 + 32'(b), b == 1);
    drain("t6", 40);
    check("t6_pkt_count", 64'(pkt_count), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
